// File: rtl/pin_driver.sv
// rtl/pin_driver.sv - GPIO/cartridge pin output driver with dead time, hold window and minimum pulse width
module pin_driver #(
    parameter int DEAD_CYC  = 2,
    parameter int HOLD_CYC  = 1,
    parameter int MIN_PULSE = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ena,
    input  logic drive_req,
    input  logic din,
    output logic pin_out,
    output logic pin_oe,
    output logic busy,
    output logic pos_edge,
    output logic neg_edge
);

    typedef enum logic [2:0] {
        S_HIZ,
        S_TURNON,
        S_DRIVE,
        S_HOLD,
        S_TURNOFF
    } state_t;

    localparam logic [3:0] DEAD_LAST  = 4'(DEAD_CYC - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYC - 1);
    localparam logic [3:0] PULSE_LAST = 4'(MIN_PULSE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] tick_cnt;
    logic [3:0] tick_nxt;
    logic [3:0] pulse_cnt;
    logic [3:0] pulse_nxt;
    logic [3:0] pulse_sat;
    logic       out_nxt;
    logic       oe_nxt;

    assign pulse_sat = (pulse_cnt == 4'hF) ? 4'hF : pulse_cnt + 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_HIZ;
            tick_cnt  <= 4'd0;
            pulse_cnt <= 4'd0;
            pin_out   <= 1'b1;
            pin_oe    <= 1'b0;
            pos_edge  <= 1'b0;
            neg_edge  <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_nxt;
            pulse_cnt <= pulse_nxt;
            pin_out   <= out_nxt;
            pin_oe    <= oe_nxt;
            // Only level changes seen while the pad is driven on both sides count as edges
            pos_edge  <= pin_oe & oe_nxt & ~pin_out & out_nxt;
            neg_edge  <= pin_oe & oe_nxt & pin_out & ~out_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        pulse_nxt = pulse_cnt;
        out_nxt   = pin_out;
        if (ena) begin
            case (state)
                S_HIZ: begin
                    if (drive_req) begin
                        out_nxt   = din;
                        tick_nxt  = 4'd0;
                        state_nxt = S_TURNON;
                    end
                end
                S_TURNON: begin
                    out_nxt = din;
                    if (!drive_req) begin
                        state_nxt = S_HIZ;
                    end else if (tick_cnt == DEAD_LAST) begin
                        state_nxt = S_DRIVE;
                        pulse_nxt = 4'd0;
                    end else begin
                        tick_nxt = tick_cnt + 4'd1;
                    end
                end
                S_DRIVE: begin
                    if (!drive_req) begin
                        pulse_nxt = pulse_sat;
                        tick_nxt  = 4'd0;
                        state_nxt = (HOLD_CYC == 0) ? S_TURNOFF : S_HOLD;
                    end else if ((din != pin_out) && (pulse_cnt >= PULSE_LAST)) begin
                        out_nxt   = din;
                        pulse_nxt = 4'd0;
                    end else begin
                        pulse_nxt = pulse_sat;
                    end
                end
                S_HOLD: begin
                    pulse_nxt = pulse_sat;
                    if (drive_req) begin
                        state_nxt = S_DRIVE;
                        tick_nxt  = 4'd0;
                    end else if (tick_cnt == HOLD_LAST) begin
                        state_nxt = S_TURNOFF;
                        tick_nxt  = 4'd0;
                    end else begin
                        tick_nxt = tick_cnt + 4'd1;
                    end
                end
                S_TURNOFF: begin
                    if (tick_cnt == DEAD_LAST) begin
                        state_nxt = S_HIZ;
                        tick_nxt  = 4'd0;
                    end else begin
                        tick_nxt = tick_cnt + 4'd1;
                    end
                end
                default: begin
                    state_nxt = S_HIZ;
                end
            endcase
        end
        oe_nxt = (state_nxt == S_DRIVE) || (state_nxt == S_HOLD);
    end

    assign busy = (state == S_TURNON) || (state == S_HOLD) || (state == S_TURNOFF);

endmodule
